uart_receiver: RTL

//  Receive side of the UART link. Deserialises RxD frames into Rx_DATA and flags framing and parity errors.
//  A frame is 1 start bit, 8 data bits LSB first, 1 even-parity bit and 1 stop bit.

---
 rtl/uart_receiver_pkg.sv | 43 ++++
 rtl/uart_baud_controller.sv | 59 +++++
 rtl/uart_receiver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_receiver_pkg.sv
// ============================================================================
//  Module  : uart_receiver_pkg
//  Brief   : Shared UART receive definitions: FSM states, data width and the
//            baud_select -> sample-tick divisor function.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
package uart_receiver_pkg;

   localparam int DATA_BITS = 8;
   localparam int DIV_W     = 14;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } rx_state_t;

   // Rounded clk_hz / (ovs * baud); only ever evaluated with constant arguments.
   function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                 input int unsigned ovs,
                                                 input logic [2:0]  sel);
      int unsigned baud;
      int unsigned den;
      case (sel)
         3'd0:    baud = 300;
         3'd1:    baud = 1200;
         3'd2:    baud = 4800;
         3'd3:    baud = 9600;
         3'd4:    baud = 19200;
         3'd5:    baud = 38400;
         3'd6:    baud = 57600;
         default: baud = 115200;
      endcase
      den = ovs * baud;
      return DIV_W'((clk_hz + den / 2) / den);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_controller.sv
// ============================================================================
//  Module  : uart_baud_controller
//  Brief   : Divisor counter producing a 1-clk sample tick every DIV clocks;
//            clr holds the phase at zero so ticks align to a start edge.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
module uart_baud_controller
   import uart_receiver_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic [2:0] baud_select,
   output logic       tick
);

   logic [DIV_W-1:0] r_cnt;
   logic             r_tick;
   logic [DIV_W-1:0] w_div;

   always_comb begin
      w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd7);
      case (baud_select)
         3'd0:    w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd0);
         3'd1:    w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd1);
         3'd2:    w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd2);
         3'd3:    w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd3);
         3'd4:    w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd4);
         3'd5:    w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd5);
         3'd6:    w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd6);
         default: w_div = baud_div(CLK_HZ, OVERSAMPLE, 3'd7);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (clr) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (r_cnt == w_div - DIV_W'(1)) begin
         r_cnt  <= '0;
         r_tick <= 1'b1;
      end else begin
         r_cnt  <= r_cnt + DIV_W'(1);
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
//  Module  : uart_receiver
//  Brief   : 8E1 UART receiver with framing/parity error flags. Define
//            RX_MAJORITY_VOTE_EN for 2-of-3 majority bit sampling.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none
module uart_receiver
   import uart_receiver_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 Rx_EN,
   input  logic [2:0]           baud_select,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] Rx_DATA,
   output logic                 Rx_FERROR,
   output logic                 Rx_PERROR,
   output logic                 Rx_VALID
);

   localparam int TCNT_W = $clog2(OVERSAMPLE);
   localparam int BIDX_W = $clog2(DATA_BITS);
   localparam logic [TCNT_W-1:0] c_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TCNT_W-1:0] c_LAST = TCNT_W'(OVERSAMPLE - 1);
   localparam logic [BIDX_W-1:0] c_BLAST = BIDX_W'(DATA_BITS - 1);

   rx_state_t            r_state, w_next;
   logic                 r_rxd_meta, r_rxd_sync, r_rxd_prev;
   logic [TCNT_W-1:0]    r_tcnt;
   logic [BIDX_W-1:0]    r_bidx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_ferr_o, r_perr_o, r_valid;
   logic                 w_tick, w_mid, w_full, w_bit, w_fall;

   uart_baud_controller #(
      .CLK_HZ     (CLK_HZ),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud (
      .clk         (clk),
      .reset       (reset),
      .clr         (r_state == S_IDLE),
      .baud_select (baud_select),
      .tick        (w_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rxd_meta <= 1'b1;
         r_rxd_sync <= 1'b1;
         r_rxd_prev <= 1'b1;
      end else begin
         r_rxd_meta <= RxD;
         r_rxd_sync <= r_rxd_meta;
         r_rxd_prev <= r_rxd_sync;
      end
   end

   assign w_fall = r_rxd_prev & ~r_rxd_sync;
   assign w_mid  = w_tick && (r_tcnt == c_MID);
   assign w_full = w_tick && (r_tcnt == c_LAST);

`ifdef RX_MAJORITY_VOTE_EN
   // Samples from the two ticks before the decision tick vote with the current one,
   // so the decision lands on the same tick as the single-sample build.
   logic [1:0] r_hist;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_hist <= 2'b11;
      else if (w_tick) r_hist <= {r_hist[0], r_rxd_sync};
   end

   assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rxd_sync) |
                  (r_hist[0] & r_rxd_sync);
`else
   assign w_bit = r_rxd_sync;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (!Rx_EN) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:   if (w_fall) w_next = S_START;
            S_START:  if (w_mid)  w_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_full && r_bidx == c_BLAST) w_next = S_PARITY;
            S_PARITY: if (w_full) w_next = S_STOP;
            S_STOP:   if (w_full) w_next = S_IDLE;
            default:  w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tcnt   <= '0;
         r_bidx   <= '0;
         r_shift  <= '0;
         r_perr   <= 1'b0;
         r_data   <= '0;
         r_ferr_o <= 1'b0;
         r_perr_o <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_state == S_IDLE || !Rx_EN) r_tcnt <= '0;
         else if (w_tick)                 r_tcnt <= r_tcnt + TCNT_W'(1);
         if (Rx_EN) begin
            case (r_state)
               S_START: begin
                  // Restart the count at mid start bit so later decisions fall mid-bit.
                  if (w_mid && !w_bit) begin
                     r_tcnt <= '0;
                     r_bidx <= '0;
                  end
               end
               S_DATA: begin
                  if (w_full) begin
                     r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                     r_bidx  <= r_bidx + BIDX_W'(1);
                  end
               end
               S_PARITY: if (w_full) r_perr <= ^{r_shift, w_bit};
               S_STOP: begin
                  if (w_full) begin
                     r_data   <= r_shift;
                     r_perr_o <= r_perr;
                     r_ferr_o <= ~w_bit;
                     r_valid  <= ~r_perr & w_bit;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign Rx_DATA   = r_data;
   assign Rx_FERROR = r_ferr_o;
   assign Rx_PERROR = r_perr_o;
   assign Rx_VALID  = r_valid;

endmodule
`default_nettype wire
